// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, reads instruction memory over req/ack and
// hands {inst, pc} to decode over valid/ready, with redirect and halt control.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_OUT
  } state_e;

  localparam logic [31:0] PC_INIT = RESET_PC & 32'hFFFF_FFFC;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] held_addr_q, held_addr_d;
  logic        squash_q, squash_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc_plus4_q, id_pc_plus4_d;

  logic [31:0] pc_plus4;
  logic [31:0] redirect_aligned;

  assign pc_plus4         = pc_q + 32'd4;
  assign redirect_aligned = redirect_pc & 32'hFFFF_FFFC;

  // An outstanding request cannot be withdrawn, so while squashing the bus keeps
  // the address captured at redirect time even though pc_q already moved on.
  assign imem_req    = (state_q == S_FETCH);
  assign imem_addr   = (state_q == S_FETCH && squash_q) ? held_addr_q : pc_q;
  assign id_valid    = id_valid_q;
  assign id_inst     = id_valid_q ? id_inst_q : NOP_INST;
  assign id_pc       = id_pc_q;
  assign id_pc_plus4 = id_pc_plus4_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    held_addr_d   = held_addr_q;
    squash_d      = squash_q;
    id_valid_d    = id_valid_q;
    id_inst_d     = id_inst_q;
    id_pc_d       = id_pc_q;
    id_pc_plus4_d = id_pc_plus4_q;

    unique case (state_q)
      S_IDLE: begin
        if (redirect) begin
          pc_d = redirect_aligned;
        end else if (!halt) begin
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        if (redirect) begin
          pc_d = redirect_aligned;
          if (imem_ack) begin
            squash_d = 1'b0;
            state_d  = halt ? S_IDLE : S_FETCH;
          end else begin
            if (!squash_q) begin
              held_addr_d = pc_q;
            end
            squash_d = 1'b1;
          end
        end else if (imem_ack) begin
          if (squash_q) begin
            squash_d = 1'b0;
            state_d  = halt ? S_IDLE : S_FETCH;
          end else begin
            id_inst_d     = imem_rdata;
            id_pc_d       = pc_q;
            id_pc_plus4_d = pc_plus4;
            id_valid_d    = 1'b1;
            pc_d          = pc_plus4;
            state_d       = S_OUT;
          end
        end
      end

      S_OUT: begin
        if (redirect) begin
          pc_d       = redirect_aligned;
          id_valid_d = 1'b0;
          state_d    = halt ? S_IDLE : S_FETCH;
        end else if (id_ready) begin
          id_valid_d = 1'b0;
          state_d    = halt ? S_IDLE : S_FETCH;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= PC_INIT;
      held_addr_q   <= PC_INIT;
      squash_q      <= 1'b0;
      id_valid_q    <= 1'b0;
      id_inst_q     <= NOP_INST;
      id_pc_q       <= '0;
      id_pc_plus4_q <= 32'd4;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      held_addr_q   <= held_addr_d;
      squash_q      <= squash_d;
      id_valid_q    <= id_valid_d;
      id_inst_q     <= id_inst_d;
      id_pc_q       <= id_pc_d;
      id_pc_plus4_q <= id_pc_plus4_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: instance A (RESET_PC=0) covers streaming, stalls,
// redirects and halt; instance B (RESET_PC=FFFF_FFFC) covers wrap and mid-fetch reset.
module tb_inst_fetch;

  localparam logic [31:0] NOP_A = 32'h0000_0013;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;

  logic        rst_n_b;
  logic        imem_req_b;
  logic [31:0] imem_addr_b;
  logic        imem_ack_b;
  logic [31:0] imem_rdata_b;
  logic        id_valid_b;
  logic [31:0] id_inst_b;
  logic [31:0] id_pc_b;
  logic [31:0] id_pc_plus4_b;

  int n_cmp = 0;
  int n_bad = 0;

  inst_fetch #(
    .RESET_PC(32'h0000_0000),
    .NOP_INST(NOP_A)
  ) dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .id_valid   (id_valid),
    .id_ready   (id_ready),
    .id_inst    (id_inst),
    .id_pc      (id_pc),
    .id_pc_plus4(id_pc_plus4),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .halt       (halt)
  );

  inst_fetch #(
    .RESET_PC(32'hFFFF_FFFC),
    .NOP_INST(32'h0000_0000)
  ) dut_b (
    .clk        (clk),
    .rst_n      (rst_n_b),
    .imem_req   (imem_req_b),
    .imem_addr  (imem_addr_b),
    .imem_ack   (imem_ack_b),
    .imem_rdata (imem_rdata_b),
    .id_valid   (id_valid_b),
    .id_ready   (1'b1),
    .id_inst    (id_inst_b),
    .id_pc      (id_pc_b),
    .id_pc_plus4(id_pc_plus4_b),
    .redirect   (1'b0),
    .redirect_pc(32'h0000_0000),
    .halt       (1'b0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called with A sitting in FETCH; completes a zero-wait read and leaves A in OUT.
  task automatic fetch_zw(input string tag, input logic [31:0] a, input logic [31:0] d);
    chk({tag, ".req"},   {31'b0, imem_req}, 32'd1);
    chk({tag, ".addr"},  imem_addr, a);
    chk({tag, ".vld0"},  {31'b0, id_valid}, 32'd0);
    imem_ack   = 1'b1;
    imem_rdata = d;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    chk({tag, ".vld1"},  {31'b0, id_valid}, 32'd1);
    chk({tag, ".inst"},  id_inst, d);
    chk({tag, ".pc"},    id_pc, a);
    chk({tag, ".pc4"},   id_pc_plus4, a + 32'd4);
    chk({tag, ".reqlo"}, {31'b0, imem_req}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b1; rst_n_b = 1'b1;
    imem_ack = 1'b0; imem_rdata = '0; id_ready = 1'b1;
    redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
    imem_ack_b = 1'b0; imem_rdata_b = '0;
    #1;
    rst_n = 1'b0; rst_n_b = 1'b0;
    tick();
    tick();

    chk("rstA.req",  {31'b0, imem_req}, 32'd0);
    chk("rstA.addr", imem_addr, 32'h0);
    chk("rstA.vld",  {31'b0, id_valid}, 32'd0);
    chk("rstA.inst", id_inst, NOP_A);
    chk("rstA.pc",   id_pc, 32'h0);
    chk("rstA.pc4",  id_pc_plus4, 32'd4);
    chk("rstB.addr", imem_addr_b, 32'hFFFF_FFFC);
    chk("rstB.pc",   id_pc_b, 32'h0);
    chk("rstB.pc4",  id_pc_plus4_b, 32'd4);

    // T1: zero-wait streaming from 0
    rst_n = 1'b1;
    chk("t1.idle", {31'b0, imem_req}, 32'd0);
    tick();
    fetch_zw("t1a", 32'h0, 32'h1000_0000);
    tick();
    fetch_zw("t1b", 32'h4, 32'h1000_0004);
    tick();
    fetch_zw("t1c", 32'h8, 32'h1000_0008);
    tick();

    // T2: decode stall holds OUT stable
    id_ready = 1'b0;
    fetch_zw("t2", 32'hC, 32'h0442_0000);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2.hvld",  {31'b0, id_valid}, 32'd1);
      chk("t2.hinst", id_inst, 32'h0442_0000);
      chk("t2.hpc",   id_pc, 32'hC);
      chk("t2.hreq",  {31'b0, imem_req}, 32'd0);
    end
    id_ready = 1'b1;
    tick();
    chk("t2.nreq",  {31'b0, imem_req}, 32'd1);
    chk("t2.naddr", imem_addr, 32'h10);

    // T3: 3 wait states, redirect one cycle after req
    tick();
    chk("t3.s1addr", imem_addr, 32'h10);
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    tick();
    redirect = 1'b0;
    chk("t3.s2req",  {31'b0, imem_req}, 32'd1);
    chk("t3.s2addr", imem_addr, 32'h10);
    chk("t3.s2vld",  {31'b0, id_valid}, 32'd0);
    tick();
    chk("t3.s3addr", imem_addr, 32'h10);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    chk("t3.dvld",  {31'b0, id_valid}, 32'd0);
    chk("t3.dinst", id_inst, NOP_A);
    fetch_zw("t3n", 32'h100, 32'h1000_0100);
    tick();

    // T4: redirect in OUT with id_ready in the same cycle
    fetch_zw("t4a", 32'h104, 32'h1000_0104);
    redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect = 1'b0;
    chk("t4.vld", {31'b0, id_valid}, 32'd0);
    fetch_zw("t4b", 32'h40, 32'h1000_0040);
    tick();

    // T3b: second redirect while squashing; exactly one response dropped
    chk("t3b.addr0", imem_addr, 32'h44);
    redirect = 1'b1; redirect_pc = 32'h80;
    tick();
    redirect_pc = 32'h8B;
    chk("t3b.addr1", imem_addr, 32'h44);
    tick();
    redirect = 1'b0;
    chk("t3b.addr2", imem_addr, 32'h44);
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_0000;
    tick();
    imem_ack = 1'b0;
    chk("t3b.vld", {31'b0, id_valid}, 32'd0);
    fetch_zw("t3bn", 32'h88, 32'h1000_0088);
    tick();

    // T6: halt during a 2-wait-state fetch
    halt = 1'b1;
    chk("t6.s0addr", imem_addr, 32'h8C);
    tick();
    chk("t6.s1req", {31'b0, imem_req}, 32'd1);
    tick();
    imem_ack = 1'b1; imem_rdata = 32'h1000_008C;
    tick();
    imem_ack = 1'b0;
    chk("t6.vld", {31'b0, id_valid}, 32'd1);
    chk("t6.pc",  id_pc, 32'h8C);
    tick();
    chk("t6.ireq", {31'b0, imem_req}, 32'd0);
    chk("t6.ivld", {31'b0, id_valid}, 32'd0);
    imem_ack = 1'b1; imem_rdata = 32'hFFFF_0000;
    tick();
    imem_ack = 1'b0;
    chk("t6.areq",  {31'b0, imem_req}, 32'd0);
    chk("t6.avld",  {31'b0, id_valid}, 32'd0);
    chk("t6.ainst", id_inst, NOP_A);
    halt = 1'b0;
    tick();
    chk("t6.rreq",  {31'b0, imem_req}, 32'd1);
    chk("t6.raddr", imem_addr, 32'h90);

    // T5: PC wrap and asynchronous reset mid-fetch on instance B
    rst_n_b = 1'b1;
    chk("t5.idle", {31'b0, imem_req_b}, 32'd0);
    tick();
    chk("t5.req",  {31'b0, imem_req_b}, 32'd1);
    chk("t5.addr", imem_addr_b, 32'hFFFF_FFFC);
    imem_ack_b = 1'b1; imem_rdata_b = 32'hCAFE_0001;
    tick();
    imem_ack_b = 1'b0;
    chk("t5.vld",  {31'b0, id_valid_b}, 32'd1);
    chk("t5.inst", id_inst_b, 32'hCAFE_0001);
    chk("t5.pc",   id_pc_b, 32'hFFFF_FFFC);
    chk("t5.pc4",  id_pc_plus4_b, 32'h0);
    tick();
    chk("t5.wreq",  {31'b0, imem_req_b}, 32'd1);
    chk("t5.waddr", imem_addr_b, 32'h0);
    tick();
    #2;
    rst_n_b = 1'b0;
    #1;
    chk("t5.rreq",  {31'b0, imem_req_b}, 32'd0);
    chk("t5.rvld",  {31'b0, id_valid_b}, 32'd0);
    chk("t5.raddr", imem_addr_b, 32'hFFFF_FFFC);
    tick();
    tick();
    rst_n_b = 1'b1;
    imem_ack_b = 1'b1; imem_rdata_b = 32'h5555_AAAA;
    tick();
    imem_ack_b = 1'b0;
    chk("t5.ivld",  {31'b0, id_valid_b}, 32'd0);
    chk("t5.ireq",  {31'b0, imem_req_b}, 32'd1);
    chk("t5.iaddr", imem_addr_b, 32'hFFFF_FFFC);
    imem_ack_b = 1'b1; imem_rdata_b = 32'hCAFE_0002;
    tick();
    imem_ack_b = 1'b0;
    chk("t5.fvld",  {31'b0, id_valid_b}, 32'd1);
    chk("t5.finst", id_inst_b, 32'hCAFE_0002);
    chk("t5.fpc",   id_pc_b, 32'hFFFF_FFFC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
